// File: rtl/nr_divider_param.sv
// ---------------------------------------------------------------------------
// nr_divider_param
//
// Sequential non-restoring divider with a width parameter, optional
// two's-complement operands, divide-by-zero detection and busy/done
// handshaking. One quotient bit is produced per clock. The block also counts
// the add and subtract operations used for each division.
//
// Parameters
//   W   operand / result width
//   CW  width of the iteration count, the m input and the op counters
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   sgn          0 = unsigned operands, 1 = two's-complement operands
//   dividend     dividend
//   divisor      divisor
//   m            significant dividend bit-length / iteration count
//                (0 or > W means W)
//   busy         high while a division is in progress
//   done         one-cycle pulse when q/rem/num_add/num_sub are valid
//   q            quotient (all ones on divide-by-zero)
//   rem          remainder, carries the dividend's sign (raw dividend on
//                divide-by-zero)
//   num_add      additions performed, including the final correction
//   num_sub      subtractions performed
//   div_by_zero  set when the accepted divisor was zero
// ---------------------------------------------------------------------------
module nr_divider_param #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sgn,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  input  logic [CW-1:0] m,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  q,
  output logic [W-1:0]  rem,
  output logic [CW-1:0] num_add,
  output logic [CW-1:0] num_sub,
  output logic          div_by_zero
);

  localparam logic [CW-1:0] W_CW = CW'(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Dividend magnitude, pre-aligned so that bit m-1 sits at the MSB; it is
  // shifted left once per iteration, so the MSB is always the next bit to
  // bring into the partial remainder. The alignment also drops the bits at
  // and above position m.
  logic [W-1:0]  num_reg;
  logic [W-1:0]  den_reg;
  logic [W-1:0]  dividend_raw_reg;
  logic [W-1:0]  quo_reg;
  // Partial remainder, two's complement, W+2 bits so that |A| < 2D always fits.
  logic [W+1:0]  a_reg;
  logic [CW-1:0] iter_reg;
  logic [CW-1:0] add_cnt_reg;
  logic [CW-1:0] sub_cnt_reg;
  logic          q_sign_reg;
  logic          r_sign_reg;

  // ---------------------------------------------------------------------
  // Operand preparation for accept
  // ---------------------------------------------------------------------
  logic [CW-1:0] m_eff;
  logic [CW-1:0] align_shamt;
  logic          dividend_neg;
  logic          divisor_neg;
  logic [W-1:0]  dividend_mag;
  logic [W-1:0]  divisor_mag;
  logic          divisor_zero;

  assign m_eff        = ((m == '0) || (m > W_CW)) ? W_CW : m;
  assign align_shamt  = W_CW - m_eff;
  assign dividend_neg = sgn & dividend[W-1];
  assign divisor_neg  = sgn & divisor[W-1];
  // The most negative value negates to itself, which read as unsigned is
  // exactly the required magnitude 2^(W-1).
  assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
  assign divisor_zero = (divisor == '0);

  // ---------------------------------------------------------------------
  // Iteration and correction arithmetic
  // ---------------------------------------------------------------------
  logic [W+1:0]  den_ext;
  logic [W+1:0]  a_shift;
  logic [W+1:0]  a_step;
  logic [W+1:0]  a_fix;
  logic [CW-1:0] add_fix;
  logic [W-1:0]  quo_signed;
  logic [W-1:0]  rem_signed;

  assign den_ext = {2'b00, den_reg};
  assign a_shift = {a_reg[W:0], num_reg[W-1]};
  // Sign of the previous A selects subtract (A >= 0) or add (A < 0).
  assign a_step  = a_reg[W+1] ? (a_shift + den_ext) : (a_shift - den_ext);

  // A negative final remainder is pulled back into [0, D) by one add.
  assign a_fix   = a_reg[W+1] ? (a_reg + den_ext) : a_reg;
  assign add_fix = add_cnt_reg + {{(CW-1){1'b0}}, a_reg[W+1]};

  // Truncating division: quotient sign is the XOR of the operand signs,
  // remainder follows the dividend.
  assign quo_signed = q_sign_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_signed = r_sign_reg ? (~a_fix[W-1:0] + 1'b1) : a_fix[W-1:0];

  assign busy = (state_reg != IDLE);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FIX : RUN;
        end
      end
      RUN: begin
        // iter_reg holds the iterations still to do, including this one.
        if (iter_reg == {{(CW-1){1'b0}}, 1'b1}) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_reg          <= '0;
      den_reg          <= '0;
      dividend_raw_reg <= '0;
      quo_reg          <= '0;
      a_reg            <= '0;
      iter_reg         <= '0;
      add_cnt_reg      <= '0;
      sub_cnt_reg      <= '0;
      q_sign_reg       <= 1'b0;
      r_sign_reg       <= 1'b0;
      done             <= 1'b0;
      q                <= '0;
      rem              <= '0;
      num_add          <= '0;
      num_sub          <= '0;
      div_by_zero      <= 1'b0;
    end else begin
      done <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_reg          <= dividend_mag << align_shamt;
            den_reg          <= divisor_mag;
            dividend_raw_reg <= dividend;
            q_sign_reg       <= dividend_neg ^ divisor_neg;
            r_sign_reg       <= dividend_neg;
            iter_reg         <= m_eff;
            a_reg            <= '0;
            quo_reg          <= '0;
            add_cnt_reg      <= '0;
            sub_cnt_reg      <= '0;
            div_by_zero      <= divisor_zero;
          end
        end
        RUN: begin
          a_reg    <= a_step;
          num_reg  <= num_reg << 1;
          quo_reg  <= {quo_reg[W-2:0], ~a_step[W+1]};
          iter_reg <= iter_reg - 1'b1;
          if (a_reg[W+1]) begin
            add_cnt_reg <= add_cnt_reg + 1'b1;
          end else begin
            sub_cnt_reg <= sub_cnt_reg + 1'b1;
          end
        end
        FIX: begin
          a_reg <= a_fix;
          if (div_by_zero) begin
            q       <= '1;
            rem     <= dividend_raw_reg;
            num_add <= '0;
            num_sub <= '0;
          end else begin
            q       <= quo_signed;
            rem     <= rem_signed;
            num_add <= add_fix;
            num_sub <= sub_cnt_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divider_param.sv
// ---------------------------------------------------------------------------
// tb_nr_divider_param
//
// Directed bench for nr_divider_param (W=32). An arithmetic model computes
// every expected result from plain integer division; a monitor compares the
// DUT against it on each done pulse and checks that results hold between
// operations. Each directed vector also carries hand-computed literals.
// ---------------------------------------------------------------------------
module tb_nr_divider_param;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sgn;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic [CW-1:0] m;
  logic          busy;
  logic          done;
  logic [W-1:0]  q;
  logic [W-1:0]  rem;
  logic [CW-1:0] num_add;
  logic [CW-1:0] num_sub;
  logic          div_by_zero;

  nr_divider_param #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sgn         (sgn),
    .dividend    (dividend),
    .divisor     (divisor),
    .m           (m),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .rem         (rem),
    .num_add     (num_add),
    .num_sub     (num_sub),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    int           add;
    int           sub;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  bit   have_held = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Truncating division on the low m bits of the magnitudes. Non-restoring
  // division always subtracts first, then subtracts after each 1 quotient bit
  // and adds after each 0 bit; a final 0 bit means a negative remainder and
  // one correcting add.
  function automatic exp_t model(logic s, logic [W-1:0] dd, logic [W-1:0] dv, int mv);
    exp_t            e;
    int              me;
    int              pc;
    logic            nn;
    logic            dn;
    logic [W-1:0]    na;
    logic [W-1:0]    nd;
    logic [W-1:0]    qt;
    logic [W-1:0]    rt;
    longint unsigned n;
    longint unsigned d;
    longint unsigned uq;
    longint unsigned ur;
    me = (mv == 0 || mv > W) ? W : mv;
    if (dv == '0) begin
      e.q = '1; e.rem = dd; e.add = 0; e.sub = 0; e.dbz = 1'b1;
      return e;
    end
    nn = s & dd[W-1];
    dn = s & dv[W-1];
    na = nn ? -dd : dd;
    nd = dn ? -dv : dv;
    n  = 64'(na) & ((64'd1 << me) - 64'd1);
    d  = 64'(nd);
    uq = n / d;
    ur = n % d;
    pc = $countones(uq >> 1);
    qt = uq[W-1:0];
    rt = ur[W-1:0];
    e.sub = 1 + pc;
    e.add = (me - 1 - pc) + (uq[0] ? 0 : 1);
    e.q   = (nn ^ dn) ? -qt : qt;
    e.rem = nn ? -rt : rt;
    e.dbz = 1'b0;
    return e;
  endfunction

  // Monitor: results on each done pulse, hold behaviour otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_q", q, e.q);
          chk("mon_rem", rem, e.rem);
          chk("mon_add", num_add, e.add);
          chk("mon_sub", num_sub, e.sub);
          chk("mon_dbz", div_by_zero, e.dbz);
          chk("mon_busy_at_done", busy, 0);
          held = e;
          have_held = 1'b1;
        end
      end else if (have_held) begin
        chk("hold_q", q, held.q);
        chk("hold_rem", rem, held.rem);
        chk("hold_add", num_add, held.add);
        chk("hold_sub", num_sub, held.sub);
      end
    end
  end

  // Drive a request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic s, input logic [W-1:0] dd, input logic [W-1:0] dv, input int mv);
    sgn      = s;
    dividend = dd;
    divisor  = dv;
    m        = CW'(mv);
    start    = 1'b1;
    exp_q.push_back(model(s, dd, dv, mv));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  // Wait (bounded) for done; returns at the negedge where done is seen.
  // With poke set, start is toggled with junk operands while busy.
  task automatic wait_done(input bit poke, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else if (poke) begin
        start    = cyc[0];
        dividend = $urandom;
        divisor  = $urandom;
        m        = CW'($urandom);
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic finish(input logic [W-1:0] lq, input logic [W-1:0] lrem, input int ladd,
                        input int lsub, input logic ldbz, input int lat, input bit poke);
    int cyc;
    wait_done(poke, cyc);
    chk("latency", cyc, lat);
    chk("lit_q", q, lq);
    chk("lit_rem", rem, lrem);
    chk("lit_add", num_add, ladd);
    chk("lit_sub", num_sub, lsub);
    chk("lit_dbz", div_by_zero, ldbz);
  endtask

  task automatic run(input logic s, input logic [W-1:0] dd, input logic [W-1:0] dv, input int mv,
                     input logic [W-1:0] lq, input logic [W-1:0] lrem, input int ladd,
                     input int lsub, input logic ldbz, input int lat, input bit poke);
    exp_t e;
    e = model(s, dd, dv, mv);
    chk("model_q", e.q, lq);
    chk("model_rem", e.rem, lrem);
    chk("model_add", e.add, ladd);
    chk("model_sub", e.sub, lsub);
    $display("op sgn=%0d %0h / %0h m=%0d", s, dd, dv, mv);
    issue(s, dd, dv, mv);
    finish(lq, lrem, ladd, lsub, ldbz, lat, poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0;
    dividend = '0; divisor = '0; m = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_rem", rem, 0);
    chk("rst_add", num_add, 0);
    chk("rst_sub", num_sub, 0);
    chk("rst_dbz", div_by_zero, 0);
    held = '{q: '0, rem: '0, add: 0, sub: 0, dbz: 1'b0};
    have_held = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Each run returns in the done cycle, so the next request is issued
    // while done is high (back-to-back accept).
    run(1'b0, 32'd7,  32'd2, 3, 32'd3, 32'd1, 1, 2, 1'b0, 4, 1'b0);
    run(1'b0, 32'd16, 32'd3, 5, 32'd5, 32'd1, 3, 2, 1'b0, 6, 1'b0);
    run(1'b0, 32'd5,  32'd7, 3, 32'd0, 32'd5, 3, 1, 1'b0, 4, 1'b0);
    run(1'b1, 32'hFFFFFFF9, 32'd2, 3, 32'hFFFFFFFD, 32'hFFFFFFFF, 1, 2, 1'b0, 4, 1'b0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 3, 32'hFFFFFFFD, 32'd1, 1, 2, 1'b0, 4, 1'b0);
    run(1'b0, 32'd5, 32'd0, 3, 32'hFFFFFFFF, 32'd5, 0, 0, 1'b1, 1, 1'b0);

    // Next valid divide clears div_by_zero; start pulses during busy ignored.
    $display("op sgn=0 10 / 3 m=5 with start pokes while busy");
    issue(1'b0, 32'd16, 32'd3, 5);
    chk("dbz_cleared", div_by_zero, 0);
    finish(32'd5, 32'd1, 3, 2, 1'b0, 6, 1'b1);

    // Boundaries: dividend bits above m ignored, m=0 and m>W mean W,
    // most negative signed dividend.
    run(1'b0, 32'hF5, 32'd2, 4, 32'd2, 32'd1, 3, 2, 1'b0, 5, 1'b0);
    run(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 29, 4, 1'b0, 33, 1'b0);
    run(1'b0, 32'd1000, 32'd10, 40, 32'd100, 32'd0, 29, 4, 1'b0, 33, 1'b0);
    run(1'b1, 32'h80000000, 32'd2, 0, 32'hC0000000, 32'd0, 31, 2, 1'b0, 33, 1'b0);

    // Asynchronous reset mid-RUN aborts with no done.
    $display("op sgn=0 201 / 41 m=10 aborted by reset");
    issue(1'b0, 32'd513, 32'd65, 10);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", q, 0);
    chk("abort_rem", rem, 0);
    chk("abort_add", num_add, 0);
    chk("abort_sub", num_sub, 0);
    chk("abort_dbz", div_by_zero, 0);
    exp_q.delete();
    held = '{q: '0, rem: '0, add: 0, sub: 0, dbz: 1'b0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    run(1'b0, 32'd256, 32'd33, 9, 32'd7, 32'd25, 6, 3, 1'b0, 10, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
